// File: rtl/dma_pkg.sv
// Shared definitions for the simple DMA controller.
//   - dma_state_e       : 3-bit controller state encoding
//   - DIR_READ/DIR_WRITE: transfer direction as latched from dma_rd_wr
//   - ACK_GUARD_DEFAULT : default dev_ack guard interval after a word strobe
package dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_DEV  = 3'd1,
        S_MEM       = 3'd2,
        S_ACK       = 3'd3,
        S_GUARD     = 3'd4,
        S_END       = 3'd5,
        S_WAIT_DROP = 3'd6
    } dma_state_e;

    localparam logic DIR_READ  = 1'b1;
    localparam logic DIR_WRITE = 1'b0;

    localparam int unsigned ACK_GUARD_DEFAULT = 2;

endpackage

// File: rtl/simple_dma_controller.sv
// Responder end of a device-to-DMA block handshake, driving the openMSP430
// DMA memory port one word per device handshake.
//   Device side : dma_rqst, dma_rd_wr, dma_start_address, dma_num_words,
//                 dev_ack, dev_out (in); dev_in, dma_ack, dma_end_flag,
//                 dma_err (out)
//   Memory side : dma_addr, dma_din, dma_en, dma_we, dma_priority (out);
//                 dma_dout, dma_ready, dma_resp (in)
// All outputs except dma_priority are registered and cleared by reset.
module simple_dma_controller
    import dma_pkg::*;
#(
    parameter int unsigned ACK_GUARD = ACK_GUARD_DEFAULT,
    parameter logic        DMA_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dma_rqst,
    input  logic        dma_rd_wr,
    input  logic [15:0] dma_start_address,
    input  logic [15:0] dma_num_words,
    input  logic        dev_ack,
    input  logic [15:0] dev_out,
    output logic [15:0] dev_in,
    output logic        dma_ack,
    output logic        dma_end_flag,
    output logic        dma_err,
    output logic [14:0] dma_addr,
    output logic [15:0] dma_din,
    output logic        dma_en,
    output logic [1:0]  dma_we,
    output logic        dma_priority,
    input  logic [15:0] dma_dout,
    input  logic        dma_ready,
    input  logic        dma_resp
);

    localparam logic [3:0] GUARD_LOAD = 4'(ACK_GUARD);

    dma_state_e  state_q, state_d;
    logic [15:0] cur_addr_q, cur_addr_d;
    logic [15:0] remaining_q, remaining_d;
    logic        dir_q, dir_d;
    logic [3:0]  guard_q, guard_d;
    logic [15:0] dev_in_q, dev_in_d;
    logic        ack_q, ack_d;
    logic        end_q, end_d;
    logic        err_q, err_d;
    logic        en_q, en_d;
    logic [14:0] addr_out_q, addr_out_d;
    logic [15:0] din_q, din_d;
    logic [1:0]  we_q, we_d;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        guard_d     = guard_q;
        dev_in_d    = dev_in_q;
        err_d       = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (dma_rqst) begin
                    cur_addr_d  = dma_start_address & 16'hFFFE;
                    remaining_d = dma_num_words;
                    dir_d       = dma_rd_wr;
                    err_d       = 1'b0;
                    state_d     = (dma_num_words == '0) ? S_END : S_WAIT_DEV;
                end
            end
            S_WAIT_DEV: begin
                if (!dma_rqst) begin
                    state_d = S_IDLE;
                end else if (dev_ack) begin
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                // dma_rqst is deliberately not looked at: an access in flight always completes.
                if (dma_ready) begin
                    if (dma_resp) begin
                        err_d   = 1'b1;
                        state_d = S_END;
                    end else begin
                        if (dir_q == DIR_READ) begin
                            dev_in_d = dma_dout;
                        end
                        cur_addr_d  = cur_addr_q + 16'd2;
                        remaining_d = remaining_q - 16'd1;
                        state_d     = S_ACK;
                    end
                end
            end
            S_ACK: begin
                guard_d = GUARD_LOAD;
                state_d = S_GUARD;
            end
            S_GUARD: begin
                guard_d = guard_q - 4'd1;
                // Leave on the cycle the counter hits zero, so GUARD lasts ACK_GUARD cycles.
                if (guard_q <= 4'd1) begin
                    guard_d = '0;
                    if (remaining_q == '0) begin
                        state_d = S_END;
                    end else if (!dma_rqst) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_DEV;
                    end
                end
            end
            S_END: begin
                state_d = S_WAIT_DROP;
            end
            S_WAIT_DROP: begin
                if (!dma_rqst) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with state_q.
        ack_d      = (state_d == S_ACK);
        end_d      = (state_d == S_END);
        en_d       = (state_d == S_MEM);
        addr_out_d = en_d ? cur_addr_d[15:1] : '0;
        we_d       = (en_d && dir_d == DIR_WRITE) ? 2'b11 : 2'b00;
        din_d      = (en_d && dir_d == DIR_WRITE) ? dev_out : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            dir_q       <= DIR_WRITE;
            guard_q     <= '0;
            dev_in_q    <= '0;
            ack_q       <= 1'b0;
            end_q       <= 1'b0;
            err_q       <= 1'b0;
            en_q        <= 1'b0;
            addr_out_q  <= '0;
            din_q       <= '0;
            we_q        <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            guard_q     <= guard_d;
            dev_in_q    <= dev_in_d;
            ack_q       <= ack_d;
            end_q       <= end_d;
            err_q       <= err_d;
            en_q        <= en_d;
            addr_out_q  <= addr_out_d;
            din_q       <= din_d;
            we_q        <= we_d;
        end
    end

    assign dev_in       = dev_in_q;
    assign dma_ack      = ack_q;
    assign dma_end_flag = end_q;
    assign dma_err      = err_q;
    assign dma_en       = en_q;
    assign dma_addr     = addr_out_q;
    assign dma_din      = din_q;
    assign dma_we       = we_q;
    assign dma_priority = DMA_PRIO;

endmodule

// File: doc/simple_dma_controller.md
Name: simple_dma_controller

Overview:
- Responder end of the device-to-DMA handshake used by DMA-capable peripherals.
- Accepts a block request (start address, word count, direction) from one device and moves words between device and memory through the openMSP430 DMA memory port, one word per handshake.
- Signals completion to the device with dma_end_flag.
- Sits between a single DMA peripheral and the core's dma_* port.

Parameters:
- ACK_GUARD, 2, cycles after a dma_ack pulse during which dev_ack is ignored; range 1..15.
- DMA_PRIO, 1'b0, constant value driven on dma_priority.

Ports:
- clk  input  1  main system clock
- reset  input  1  asynchronous active-high reset
- dma_rqst  input  1  device block request (level)
- dma_rd_wr  input  1  1 = memory read to device, 0 = device write to memory
- dma_start_address  input  16  byte start address; bit 0 ignored
- dma_num_words  input  16  words to transfer
- dev_ack  input  1  device ready for next word
- dev_out  input  16  write data from device
- dev_in  output  16  read data to device
- dma_ack  output  1  one-cycle word-complete strobe
- dma_end_flag  output  1  one-cycle block-complete strobe
- dma_err  output  1  sticky; memory responded with error
- dma_addr  output  15  word address to memory
- dma_din  output  16  write data to memory
- dma_en  output  1  memory access enable
- dma_we  output  2  byte write enables
- dma_priority  output  1  equals DMA_PRIO
- dma_dout  input  16  read data from memory
- dma_ready  input  1  access complete this cycle
- dma_resp  input  1  error response, valid with dma_ready

Behaviour:
- Reset values:
  - all outputs 0, except dma_priority = DMA_PRIO.
  - State returns to IDLE; address register, count register, dev_in, guard counter and dma_err are all cleared.
- States: IDLE, WAIT_DEV, MEM, ACK, GUARD, END, WAIT_DROP.
- IDLE:
  - On dma_rqst = 1, latch cur_addr = {dma_start_address[15:1], 0}, remaining = dma_num_words, dir = dma_rd_wr, and clear dma_err.
  - If remaining == 0, go to END; otherwise go to WAIT_DEV.
- WAIT_DEV:
  - If dma_rqst = 0, go to IDLE (abort, no end flag).
  - Else if dev_ack = 1, go to MEM.
- MEM:
  - dma_en = 1, dma_addr = cur_addr[15:1].
  - Write: dma_we = 2'b11 and dma_din = dev_out, sampled on each cycle of MEM.
  - Read: dma_we = 2'b00.
  - Hold all of these until dma_ready. dma_rqst is ignored here; an access is never dropped.
  - On dma_ready with dma_resp = 1: set dma_err, go to END.
  - On dma_ready with dma_resp = 0:
    - Read: dev_in <= dma_dout.
    - cur_addr += 2, wrapping 0xFFFE -> 0x0000.
    - remaining -= 1.
    - Go to ACK.
- ACK:
  - dma_ack = 1 for exactly one cycle. dev_in is already stable in this cycle.
  - Load guard counter = ACK_GUARD, go to GUARD.
- GUARD:
  - Decrement the guard counter; dev_ack is ignored.
  - When the counter reaches 0: if remaining == 0 go to END, else if dma_rqst = 0 go to IDLE, else go to WAIT_DEV.
- END: dma_end_flag = 1 for one cycle, go to WAIT_DROP.
- WAIT_DROP: stay until dma_rqst = 0, then go to IDLE.
  - A new transfer needs a request low-then-high transition.
- Timing:
  - Latency from dev_ack high in WAIT_DEV to dma_en high is 1 cycle.
  - A zero-wait memory access (dma_ready in the first MEM cycle) gives a per-word cost of 3 + ACK_GUARD cycles, plus the dev_ack wait.
- dev_in holds its last read value until the next read completes or reset.
- dma_ack is never asserted in the same cycle as dma_end_flag.
- Reset mid-operation: immediate return to IDLE and the reset values above. An in-flight memory access is abandoned; the core handles this because reset is shared.
- dma_num_words = 0xFFFF is legal. remaining is 16 bits with no overflow; the transfer runs 65535 words.

Decomposition:
- Shared package (dma_pkg): state encodings (3-bit), DIR_READ = 1 / DIR_WRITE = 0, default ACK_GUARD.
- Sub-module: none required. The guard counter and the address/count datapath stay inline; the FSM is a single always block plus registered outputs.

Test Plan:
- Read block: start 0x0200, n = 3, rd_wr = 1, dev_ack tied 1, memory returns 0xA1, 0xB2, 0xC3 with zero wait -> dma_addr 0x100, 0x101, 0x102; three dma_ack pulses with dev_in = 0xA1, 0xB2, 0xC3; one dma_end_flag after the third GUARD.
- Write block with handshake: n = 2, rd_wr = 0, dev_out = 0x1234 then 0x5678, dev_ack pulsed by the bench -> dma_we = 11 with matching dma_din at addresses 0x100 and 0x101; no MEM entry before each dev_ack pulse.
- Zero words: n = 0, rqst 0->1 -> dma_end_flag on cycle 2, no dma_en; controller stays in WAIT_DROP until rqst drops.
- Wait states and error: dma_ready delayed 4 cycles -> dma_en/dma_addr stable for 4 cycles. Then dma_resp = 1 on word 2 -> dma_err = 1, dma_end_flag pulse, no second dma_ack.
- Abort and wrap: start 0xFFFE, n = 3; rqst dropped during the second MEM -> the access completes, dma_ack pulses, addresses are 0x7FFF then 0x0000, controller returns to IDLE with no end flag.
- Async reset asserted mid-MEM -> all outputs 0 in the same cycle; a fresh request afterwards runs normally.
